// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: word width, NOP encoding and fetch FSM states.
package fetch_unit_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
    localparam logic [WORD_WIDTH-1:0] NOP_INST  = ZERO_WORD;

    localparam int unsigned IF_ST_W = 2;

    typedef enum logic [IF_ST_W-1:0] {
        IF_ST_IDLE,
        IF_ST_REQ,
        IF_ST_HOLD,
        IF_ST_DRAIN
    } if_state_t;

endpackage

// File: rtl/fetch_unit_skid.sv
// One-entry skid register (word + pc) catching a fetch that completes while the decoder stalls.
module if_skid_buf
    import fetch_unit_pkg::*;
#(
    parameter int unsigned W = WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  logic [W-1:0] word_in,
    input  logic [W-1:0] pc_in,
    output logic [W-1:0] word_out,
    output logic [W-1:0] pc_out,
    output logic         full
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_out <= '0;
            pc_out   <= '0;
            full     <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            word_out <= word_in;
            pc_out   <= pc_in;
            full     <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack handshake and
// presents a registered instruction, its PC and a valid flag to the decoder.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned    W        = WORD_WIDTH,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] redirect_pc,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc,
    output logic [W-1:0] pc_plus4,
    output logic         inst_valid
);

    localparam logic [W-1:0] NOP_W = W'(NOP_INST);

    if_state_t    state;
    logic [W-1:0] pc;
    logic [W-1:0] pc_next4;
    logic [W-1:0] redir_pc;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_clear;
    logic         skid_full;
    logic [W-1:0] skid_word;
    logic [W-1:0] skid_pc;

    assign redir_pc = redirect_pc & ~W'(3);
    assign pc_next4 = pc + W'(4);

    always_comb begin
        skid_load   = (state == IF_ST_REQ) && imem_ack && stall && !flush;
        skid_unload = (state == IF_ST_HOLD) && skid_full && !stall && !flush;
        skid_clear  = flush;
    end

    if_skid_buf #(.W(W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (skid_clear),
        .word_in  (imem_rdata),
        .pc_in    (pc),
        .word_out (skid_word),
        .pc_out   (skid_pc),
        .full     (skid_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IF_ST_IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst       <= NOP_W;
            inst_pc    <= '0;
            pc_plus4   <= W'(4);
            inst_valid <= 1'b0;
        end else if (flush) begin
            pc         <= redir_pc;
            inst       <= NOP_W;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            // An un-acked request must finish at its old address before the redirect is issued.
            if ((state == IF_ST_REQ || state == IF_ST_DRAIN) && !imem_ack) begin
                state <= IF_ST_DRAIN;
            end else begin
                state     <= IF_ST_REQ;
                imem_addr <= redir_pc;
            end
        end else begin
            case (state)
                IF_ST_IDLE: begin
                    state     <= IF_ST_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                IF_ST_REQ: begin
                    if (imem_ack) begin
                        pc <= pc_next4;
                        if (stall) begin
                            state    <= IF_ST_HOLD;
                            imem_req <= 1'b0;
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            pc_plus4   <= pc_next4;
                            inst_valid <= 1'b1;
                            imem_addr  <= pc_next4;
                        end
                    end else if (!stall) begin
                        inst       <= NOP_W;
                        inst_valid <= 1'b0;
                    end
                end
                IF_ST_HOLD: begin
                    if (skid_unload) begin
                        inst       <= skid_word;
                        inst_pc    <= skid_pc;
                        pc_plus4   <= skid_pc + W'(4);
                        inst_valid <= 1'b1;
                        state      <= IF_ST_REQ;
                        imem_req   <= 1'b1;
                        imem_addr  <= pc;
                    end
                end
                IF_ST_DRAIN: begin
                    inst       <= NOP_W;
                    inst_valid <= 1'b0;
                    if (imem_ack) begin
                        state     <= IF_ST_REQ;
                        imem_addr <= pc;
                    end
                end
            endcase
        end
    end

endmodule
